// File: rtl/synth_pkg.sv
// Shared types for the voice allocator: widths, voice table entry, command and FSM state.
// Pure declarations, no timing.
// Age field is sized for the widest supported counter; the allocator saturates it at its own AGE_W.
package synth_pkg;

  localparam int NOTE_W      = 7;
  localparam int FCW_W       = 24;
  localparam int AGE_FIELD_W = 16;

  typedef struct packed {
    logic                   en;
    logic [NOTE_W-1:0]      note;
    logic [FCW_W-1:0]       fcw;
    logic [AGE_FIELD_W-1:0] age;
  } voice_entry_t;

  typedef struct packed {
    logic              is_on;
    logic [NOTE_W-1:0] note;
    logic [FCW_W-1:0]  fcw;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    COMMIT,
    REQ,
    RELEASE
  } alloc_state_e;

  // Increment an age counter, holding it at age_max once reached.
  function automatic logic [AGE_FIELD_W-1:0] age_sat_inc(
    input logic [AGE_FIELD_W-1:0] age,
    input logic [AGE_FIELD_W-1:0] age_max
  );
    return (age >= age_max) ? age : age + 1'b1;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Command bus from the CPU note MMIOs plus the voice bank / 4-phase handshake toward the CDC.
// No logic; master = CPU/CDC side, slave = allocator.
// cmd_valid/cmd_ready back-pressure; req/ack is a full 4-phase handshake.
interface voice_allocator_if #(parameter int N_VOICES = 4);
  import synth_pkg::*;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic                        cmd_on;
  logic [NOTE_W-1:0]           cmd_note;
  logic [FCW_W-1:0]            cmd_fcw;
  logic [N_VOICES*FCW_W-1:0]   carrier_fcws;
  logic [N_VOICES-1:0]         note_en;
  logic                        req;
  logic                        ack;

  modport master (
    output cmd_valid, cmd_on, cmd_note, cmd_fcw, ack,
    input  cmd_ready, carrier_fcws, note_en, req
  );

  modport slave (
    input  cmd_valid, cmd_on, cmd_note, cmd_fcw, ack,
    output cmd_ready, carrier_fcws, note_en, req
  );

endinterface

// File: rtl/voice_allocator_select.sv
// Voice search: note match, first free voice and oldest voice over the voice table.
// Purely combinational, zero latency.
// No handshake; results are consumed by the allocator FSM in its SCAN state.
module voice_select
  import synth_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1
) (
  input  voice_entry_t      tbl_i [N_VOICES],
  input  logic [NOTE_W-1:0] note_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  hit_idx_o,
  output logic              free_o,
  output logic [IDX_W-1:0]  free_idx_o,
  output logic [IDX_W-1:0]  oldest_idx_o
);

  logic [AGE_FIELD_W-1:0] best_age;

  // Fixed-priority searches: lowest index wins; oldest uses strict '>' so ties keep the lower index.
  always_comb begin
    hit_o        = 1'b0;
    hit_idx_o    = '0;
    free_o       = 1'b0;
    free_idx_o   = '0;
    oldest_idx_o = '0;
    best_age     = tbl_i[0].age;
    for (int i = 0; i < N_VOICES; i++) begin
      if (!hit_o && tbl_i[i].en && (tbl_i[i].note == note_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = IDX_W'(i);
      end
      if (!free_o && !tbl_i[i].en) begin
        free_o     = 1'b1;
        free_idx_o = IDX_W'(i);
      end
      if (tbl_i[i].age > best_age) begin
        best_age     = tbl_i[i].age;
        oldest_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Note scheduler: maps note-on/off commands onto N_VOICES voices (oldest-voice stealing) and publishes via req/ack.
// Accept at cycle 0, SCAN 1, COMMIT 2, req high at 3; one command in flight until ack falls.
// cmd_ready is low whenever the FSM is not IDLE; build macro VOICE_ALLOC_STEAL_EN enables stealing.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int N_VOICES = 4,
  parameter int AGE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  voice_allocator_if.slave   bus,
  output logic               cmd_dropped,
  output logic               busy
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [AGE_FIELD_W-1:0] AGE_MAX = AGE_FIELD_W'((1 << AGE_W) - 1);

  alloc_state_e       state_q, state_d;
  cmd_t               cmd_q;
  voice_entry_t       tbl_q [N_VOICES];
  logic [IDX_W-1:0]   sel_idx_q, sel_idx_d;

  logic               hit, free;
  logic [IDX_W-1:0]   hit_idx, free_idx, oldest_idx;

  voice_select #(.N_VOICES(N_VOICES), .IDX_W(IDX_W)) u_select (
    .tbl_i        (tbl_q),
    .note_i       (cmd_q.note),
    .hit_o        (hit),
    .hit_idx_o    (hit_idx),
    .free_o       (free),
    .free_idx_o   (free_idx),
    .oldest_idx_o (oldest_idx)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: SCAN either commits a chosen voice or abandons the command with no table change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = SCAN;
      SCAN: begin
        if (cmd_q.is_on) begin
          if (hit || free) begin
            state_d = COMMIT;
          end else begin
`ifdef VOICE_ALLOC_STEAL_EN
            state_d = COMMIT;
`else
            state_d = IDLE;
`endif
          end
        end else begin
          state_d = hit ? COMMIT : IDLE;
        end
      end
      COMMIT:  state_d = REQ;
      REQ:     if (bus.ack)  state_d = RELEASE;
      RELEASE: if (!bus.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from state; req drops as soon as reset forces IDLE.
  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.req       = (state_q == REQ);
    busy          = (state_q != IDLE);
`ifdef VOICE_ALLOC_STEAL_EN
    cmd_dropped   = 1'b0;
`else
    cmd_dropped   = (state_q == SCAN) && cmd_q.is_on && !hit && !free;
`endif
  end

  // Voice choice: retrigger beats free beats oldest; note-off only reaches COMMIT on a hit.
  always_comb begin
    if (!cmd_q.is_on || hit) sel_idx_d = hit_idx;
    else if (free)           sel_idx_d = free_idx;
    else                     sel_idx_d = oldest_idx;
  end

  // Latch the accepted command so the table search sees stable inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     cmd_q <= '0;
    else if (state_q == IDLE && bus.cmd_valid)   cmd_q <= {bus.cmd_on, bus.cmd_note, bus.cmd_fcw};
  end

  // Hold the SCAN decision for the COMMIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   sel_idx_q <= '0;
    else if (state_q == SCAN)  sel_idx_q <= sel_idx_d;
  end

  // Table write only in COMMIT, so the bank is stable whenever req or ack is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < N_VOICES; v++) tbl_q[v] <= '0;
    end else if (state_q == COMMIT) begin
      for (int v = 0; v < N_VOICES; v++) begin
        if (IDX_W'(v) == sel_idx_q) begin
          tbl_q[v].en  <= cmd_q.is_on;
          tbl_q[v].age <= '0;
          if (cmd_q.is_on) begin
            tbl_q[v].note <= cmd_q.note;
            tbl_q[v].fcw  <= cmd_q.fcw;
          end
        end else if (tbl_q[v].en) begin
          tbl_q[v].age <= age_sat_inc(tbl_q[v].age, AGE_MAX);
        end
      end
    end
  end

  // Flatten the table into the CDC-facing voice bank.
  always_comb begin
    bus.carrier_fcws = '0;
    bus.note_en      = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      bus.carrier_fcws[v*FCW_W +: FCW_W] = tbl_q[v].fcw;
      bus.note_en[v]                     = tbl_q[v].en;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (N_VOICES=4, AGE_W=2) with a req/ack responder and scoreboard monitor.
// Expected bank contents are queued per command; the monitor checks them at every req rise.
// Works with VOICE_ALLOC_STEAL_EN defined or undefined.
module tb_voice_allocator;
  import synth_pkg::*;

  localparam int NV = 4;
  localparam int FW = FCW_W;
`ifdef VOICE_ALLOC_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic cmd_dropped, busy;

  voice_allocator_if #(.N_VOICES(NV)) bus();

  voice_allocator #(.N_VOICES(NV), .AGE_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .cmd_dropped (cmd_dropped),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                  drop;
    logic [NV-1:0]       en;
    logic [NV*FW-1:0]    fcws;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   hold_ack = 1'b0;

  function automatic logic [NV*FW-1:0] pk(input logic [23:0] v3, input logic [23:0] v2,
                                          input logic [23:0] v1, input logic [23:0] v0);
    return {v3, v2, v1, v0};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic expect_hs(input logic [NV-1:0] en, input logic [NV*FW-1:0] f);
    exp_t e;
    e.drop = 1'b0; e.en = en; e.fcws = f;
    exp_q.push_back(e);
  endtask

  task automatic expect_drop();
    exp_t e;
    e.drop = 1'b1; e.en = '0; e.fcws = '0;
    exp_q.push_back(e);
  endtask

  // CDC-side responder: ack two cycles after req, drop ack once req falls.
  int rc = 0;
  initial begin
    bus.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.ack = 1'b0; rc = 0;
      end else if (bus.req && !bus.ack && !hold_ack) begin
        rc++;
        if (rc >= 2) begin bus.ack = 1'b1; rc = 0; end
      end else if (!bus.req && bus.ack) begin
        bus.ack = 1'b0;
      end
    end
  end

  // Scoreboard monitor: table at req rise, bank stability until ack falls, dropped pulses.
  logic              prev_req = 1'b0;
  bit                in_hs = 1'b0;
  bit                stable = 1'b1;
  logic [NV-1:0]     snap_en;
  logic [NV*FW-1:0]  snap_f;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_hs = 1'b0; prev_req = 1'b0;
      end else begin
        if (bus.req && !prev_req) begin
          if (exp_q.size() == 0) fail_now("unexpected_req");
          else begin
            e = exp_q.pop_front();
            if (e.drop) fail_now("req_where_drop_expected");
            else check("hs_table", {bus.note_en, bus.carrier_fcws}, {e.en, e.fcws});
          end
          snap_en = bus.note_en; snap_f = bus.carrier_fcws;
          in_hs = 1'b1; stable = 1'b1;
        end else if (in_hs) begin
          if (bus.note_en !== snap_en || bus.carrier_fcws !== snap_f) stable = 1'b0;
          if (!bus.req && !bus.ack) begin
            check("hs_stable", 128'(stable), 128'd1);
            in_hs = 1'b0;
          end
        end
        if (cmd_dropped) begin
          if (exp_q.size() == 0) fail_now("unexpected_drop");
          else begin
            e = exp_q.pop_front();
            if (!e.drop) fail_now("drop_where_req_expected");
            else check("drop_pulse", 128'(cmd_dropped), 128'd1);
          end
        end
        prev_req = bus.req;
      end
    end
  end

  task automatic send(input bit on, input logic [6:0] note, input logic [23:0] fcw);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_on = on; bus.cmd_note = note; bus.cmd_fcw = fcw;
    while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) fail_now("accept_timeout");
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || bus.ack) && n < 200) begin @(negedge clk); n++; end
    if (busy || bus.ack) fail_now("idle_timeout");
  endtask

  logic [23:0] v0;
  bit          ok;
  int          n;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_on = 1'b0; bus.cmd_note = '0; bus.cmd_fcw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rst_ready",   128'(bus.cmd_ready), 128'd1);
    check("rst_outputs", 128'({bus.req, busy, cmd_dropped}), 128'd0);
    check("rst_bank",    128'({bus.note_en, bus.carrier_fcws}), 128'd0);

    // First note-on with latency check: req low in COMMIT cycle, high in the next.
    expect_hs(4'b0001, pk(24'h0, 24'h0, 24'h0, 24'h0A0000));
    send(1'b1, 7'd60, 24'h0A0000);
    @(negedge clk); check("lat_scan_busy", 128'({busy, bus.req}), 128'b10);
    @(negedge clk); check("lat_commit_req", 128'(bus.req), 128'd0);
    @(negedge clk); check("lat_req_rise", 128'(bus.req), 128'd1);
    wait_idle();

    expect_hs(4'b0011, pk(24'h0, 24'h0, 24'h0B0000, 24'h0A0000));
    send(1'b1, 7'd62, 24'h0B0000); wait_idle();
    expect_hs(4'b0111, pk(24'h0, 24'h0C0000, 24'h0B0000, 24'h0A0000));
    send(1'b1, 7'd64, 24'h0C0000); wait_idle();
    expect_hs(4'b1111, pk(24'h0D0000, 24'h0C0000, 24'h0B0000, 24'h0A0000));
    send(1'b1, 7'd65, 24'h0D0000); wait_idle();

    // All busy: steal voice0 (age 3) or drop.
    v0 = STEAL ? 24'h0E0000 : 24'h0A0000;
    if (STEAL) expect_hs(4'b1111, pk(24'h0D0000, 24'h0C0000, 24'h0B0000, 24'h0E0000));
    else       expect_drop();
    send(1'b1, 7'd67, 24'h0E0000); wait_idle();
    check("after_full_on", {bus.note_en, bus.carrier_fcws}, {4'b1111, pk(24'h0D0000, 24'h0C0000, 24'h0B0000, v0)});

    expect_hs(4'b1101, pk(24'h0D0000, 24'h0C0000, 24'h0B0000, v0));
    send(1'b0, 7'd62, 24'h0); wait_idle();

    // Note-off of an inactive note: no handshake, ready again after SCAN.
    send(1'b0, 7'd70, 24'h0);
    @(negedge clk); check("off_miss_scan_ready", 128'(bus.cmd_ready), 128'd0);
    @(negedge clk); check("off_miss_idle_ready", 128'(bus.cmd_ready), 128'd1);
    check("off_miss_table", {bus.note_en, bus.carrier_fcws}, {4'b1101, pk(24'h0D0000, 24'h0C0000, 24'h0B0000, v0)});

    // Retrigger of note 64 twice: voice2 only, enables unchanged.
    expect_hs(4'b1101, pk(24'h0D0000, 24'h0C1000, 24'h0B0000, v0));
    send(1'b1, 7'd64, 24'h0C1000); wait_idle();
    expect_hs(4'b1101, pk(24'h0D0000, 24'h0C2000, 24'h0B0000, v0));
    send(1'b1, 7'd64, 24'h0C2000); wait_idle();
    expect_hs(4'b1111, pk(24'h0D0000, 24'h0C2000, 24'h0F0000, v0));
    send(1'b1, 7'd72, 24'h0F0000); wait_idle();

    // Voice0 and voice3 both saturated at age 3: tie goes to voice0.
    if (STEAL) begin
      v0 = 24'h100000;
      expect_hs(4'b1111, pk(24'h0D0000, 24'h0C2000, 24'h0F0000, v0));
    end else begin
      expect_drop();
    end
    send(1'b1, 7'd74, 24'h100000); wait_idle();
    check("sat_steal_table", {bus.note_en, bus.carrier_fcws}, {4'b1111, pk(24'h0D0000, 24'h0C2000, 24'h0F0000, v0)});

    // Hold ack low: req stays high, new command back-pressured; then reset mid-REQ.
    hold_ack = 1'b1;
    expect_hs(4'b1101, pk(24'h0D0000, 24'h0C2000, 24'h0F0000, v0));
    send(1'b0, 7'd72, 24'h0);
    n = 0;
    while (!bus.req && n < 20) begin @(negedge clk); n++; end
    check("hold_req_seen", 128'(bus.req), 128'd1);
    bus.cmd_valid = 1'b1; bus.cmd_on = 1'b1; bus.cmd_note = 7'd80; bus.cmd_fcw = 24'h111111;
    ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!bus.req || bus.cmd_ready || !busy) ok = 1'b0;
    end
    check("hold_stall", 128'(ok), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 128'(bus.req), 128'd0);
    check("async_rst_bank", {bus.note_en, bus.carrier_fcws}, 128'd0);
    bus.cmd_valid = 1'b0;
    hold_ack = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 128'({bus.cmd_ready, busy}), 128'b10);

    expect_hs(4'b0001, pk(24'h0, 24'h0, 24'h0, 24'h0A0000));
    send(1'b1, 7'd60, 24'h0A0000); wait_idle();

    repeat (5) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
